ccu_compare_channel: RTL and testbench
======================================

# ccu_compare_channel

One capture/compare channel of the R80515 capture/compare unit (CCU). It holds the 16-bit CCLx/CCHx register pair and compares it against the timer 2 count. It produces the registered `compare` and `ov` strobes and the `cocahl` mode that the downstream CCU port stage uses to drive its port pin. In capture modes it latches the timer 2 count on an external pin edge or on a software write.

## Interface
Parameters:
- CCL_ID, 7'h42 – SFR address (`sfraddr` encoding) of the low byte.
- CCH_ID, 7'h43 – SFR address of the high byte.

Ports:
- clk  in  1  global clock.
- rst  in  1  reset; synchronous, active-high; clock clk.
- t2_count  in  16  timer 2 current count.
- t2_ov  in  1  timer 2 overflow/reload pulse, one cycle.
- capin  in  1  asynchronous external capture pin.
- ccen_mode  in  2  mode field from CCEN. 00 off, 01 capture on rising capin, 10 compare, 11 capture on CCL write.
- sfrdatai  in  8  SFR write data.
- sfraddr  in  7  SFR address.
- sfrwe  in  1  SFR write enable.
- sfrdatao  out  8  read data; active byte when `sfraddr` hits CCL_ID/CCH_ID, else 8'h00. Combinational.
- compare  out  1  registered compare-match strobe, one cycle.
- ov  out  1  registered copy of t2_ov, aligned with `compare`.
- cocahl  out  2  registered copy of ccen_mode, aligned with `compare`.
- irq  out  1  one-cycle request on compare match (mode 10) or capture (01/11).

## Operation
- Registers:
  - `cc_act[15:0]`: compared and read back.
  - `cc_shd[15:0]`: software write target.
- SFR writes:
  - Writes to CCL_ID/CCH_ID update the matching byte of `cc_shd`, in every mode except 11 (see below).
  - `cc_act` is loaded from `cc_shd` immediately when mode ≠ 10.
  - In mode 10, `cc_act` loads only in the cycle `t2_ov` is high. This gives glitch-free reload.
  - If a write and `t2_ov` occur in the same cycle, `cc_act` takes the post-write shadow value.
- Compare (mode 10):
  - `match = (t2_count == cc_act)`; `match_prev` is registered every cycle.
  - `compare` = 1 in the cycle after `match & !match_prev`. A stopped timer sitting on the value gives exactly one strobe.
  - `irq` is asserted together with `compare`.
  - `compare` is 0 in all other modes.
- Capture mode 01:
  - `capin` passes through a 2-flop synchronizer; a rising edge is taken from the synchronized value.
  - On the edge, `t2_count` is loaded into both `cc_act` and `cc_shd`, and `irq` pulses.
  - A capture has priority over an SFR write in the same cycle.
- Capture mode 11:
  - A write to CCL_ID captures `t2_count` (sampled in the write cycle) into `cc_act`/`cc_shd`; the write data is discarded. `irq` pulses.
  - CCH_ID writes behave as normal writes.
- Mode 00: no compare, no capture, no `irq`. Registers remain writable and readable.
- The synchronizer and edge history run in all modes, so entering mode 01 with `capin` already high causes no capture.
- `match_prev` resets to 1, so a zero register against a zero count after reset gives no strobe.

## Timing
- Reset values:
  - `compare`, `ov`, `irq` = 0; `cocahl` = 2'b00.
  - `cc_act`, `cc_shd` = 16'h0000; synchronizer flops = 0; `match_prev` = 1.
- Compare latency: 1 clk from the count reaching the value to `compare`.
- `ov`/`cocahl` latency: 1 clk, aligned with `compare`.
- Capture latency (mode 01): 3 clk from `capin` rising to `cc_act` update. `irq` asserts in the same cycle as the update.
- Capture on write (mode 11): `cc_act` holds the new value 1 clk after the write cycle; `irq` is asserted in that cycle.
- Reset mid-operation: all state is cleared on the next edge, and any in-flight synchronizer edge is dropped.
- Mode change: takes effect in the cycle `ccen_mode` changes. `cocahl` follows one cycle later.

## Structure
- The shared constants file (utility) holds:
  - CCL1_ID..CCH3_ID address constants;
  - mode encodings CC_OFF, CC_CAPEDGE, CC_COMPARE, CC_CAPWR.
- One sub-module, `ccu_capsync`: 2-flop synchronizer plus rising-edge detector, with synchronous reset to 0.

## Test plan
- Mode 10, `cc` = 16'h1234, count 1232→1236 → `compare` and `irq` high for one cycle, one clk after count = 1234; no strobe afterwards.
- Mode 10 with timer held at 1234 for 10 cycles → exactly one `compare` pulse.
- Mode 10, write CCL = 8'h00 mid-period → `cc_act` unchanged until the `t2_ov` cycle; readback is the old value until then.
- Mode 01, count = 16'hABCD, `capin` 0→1 → `cc_act` = ABCD after 3 clk; `irq` pulse; CCL read = 8'hCD.
- Mode 11, write 8'h55 to CCL with count = 16'h0F0F → `cc_act` = 0F0F (not 55); `irq` pulse.
- `rst` asserted mid-capture (`capin` rising one cycle earlier) → no capture, all outputs 0, `cc_act` = 0.

Source files
------------

// File: rtl/ccu_compare_channel_pkg.sv
// Shared constants for the CCU capture/compare channels: SFR addresses and mode encodings.
package ccu_compare_channel_pkg;

  // Seven-bit SFR addresses of the CCLx/CCHx register pairs.
  localparam logic [6:0] CCL1_ID = 7'h42;
  localparam logic [6:0] CCH1_ID = 7'h43;
  localparam logic [6:0] CCL2_ID = 7'h44;
  localparam logic [6:0] CCH2_ID = 7'h45;
  localparam logic [6:0] CCL3_ID = 7'h46;
  localparam logic [6:0] CCH3_ID = 7'h47;

  // Channel mode field from CCEN.
  typedef enum logic [1:0] {
    CC_OFF     = 2'b00,
    CC_CAPEDGE = 2'b01,
    CC_COMPARE = 2'b10,
    CC_CAPWR   = 2'b11
  } cc_mode_e;

endpackage

// File: rtl/ccu_compare_channel_capsync.sv
// Two-flop synchronizer for the asynchronous capture pin plus a rising-edge detector.
module ccu_capsync
  import ccu_compare_channel_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic capin,
  output logic rise
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Synchronizer chain and edge history; reset drops any edge in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= capin;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/ccu_compare_channel.sv
// One CCU capture/compare channel: CCLx/CCHx register pair, compare against timer 2,
// capture on pin edge or on CCL write.
module ccu_compare_channel
  import ccu_compare_channel_pkg::*;
#(
  parameter logic [6:0] CCL_ID = CCL1_ID,
  parameter logic [6:0] CCH_ID = CCH1_ID
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] t2_count,
  input  logic        t2_ov,
  input  logic        capin,
  input  logic [1:0]  ccen_mode,
  input  logic [7:0]  sfrdatai,
  input  logic [6:0]  sfraddr,
  input  logic        sfrwe,
  output logic [7:0]  sfrdatao,
  output logic        compare,
  output logic        ov,
  output logic [1:0]  cocahl,
  output logic        irq
);

  cc_mode_e    mode;
  logic        rise;
  logic        wr_l;
  logic        wr_h;
  logic        cap_edge;
  logic        cap_wr;
  logic        match;
  logic        cmp_d;
  logic [15:0] cc_act_q, cc_act_d;
  logic [15:0] cc_shd_q, cc_shd_d;
  logic        match_prev_q;
  logic        compare_q;
  logic        ov_q;
  logic [1:0]  cocahl_q;
  logic        irq_q;

  assign mode = cc_mode_e'(ccen_mode);

  ccu_capsync u_capsync (
    .clk   (clk),
    .rst   (rst),
    .capin (capin),
    .rise  (rise)
  );

  assign wr_l     = sfrwe && (sfraddr == CCL_ID);
  assign wr_h     = sfrwe && (sfraddr == CCH_ID);
  assign cap_edge = (mode == CC_CAPEDGE) && rise;
  assign cap_wr   = (mode == CC_CAPWR) && wr_l;
  assign match    = (t2_count == cc_act_q);
  assign cmp_d    = (mode == CC_COMPARE) && match && !match_prev_q;

  // Shadow/active next state: captures win over writes; compare mode reloads only on t2_ov.
  always_comb begin
    cc_shd_d = cc_shd_q;
    if (wr_l && (mode != CC_CAPWR)) cc_shd_d[7:0] = sfrdatai;
    if (wr_h) cc_shd_d[15:8] = sfrdatai;
    if (cap_edge || cap_wr) cc_shd_d = t2_count;

    cc_act_d = cc_act_q;
    if (cap_edge || cap_wr) begin
      cc_act_d = t2_count;
    end else if (mode != CC_COMPARE || t2_ov) begin
      // Post-write shadow so a write coinciding with t2_ov is not lost.
      cc_act_d = cc_shd_d;
    end
  end

  // Channel registers and registered strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cc_act_q     <= 16'h0000;
      cc_shd_q     <= 16'h0000;
      match_prev_q <= 1'b1;  // zero register vs zero count after reset must not strobe
      compare_q    <= 1'b0;
      ov_q         <= 1'b0;
      cocahl_q     <= 2'b00;
      irq_q        <= 1'b0;
    end else begin
      cc_act_q     <= cc_act_d;
      cc_shd_q     <= cc_shd_d;
      match_prev_q <= match;
      compare_q    <= cmp_d;
      ov_q         <= t2_ov;
      cocahl_q     <= ccen_mode;
      irq_q        <= cmp_d || cap_edge || cap_wr;
    end
  end

  // Read mux returns the active register bytes.
  always_comb begin
    sfrdatao = 8'h00;
    if (sfraddr == CCL_ID) sfrdatao = cc_act_q[7:0];
    else if (sfraddr == CCH_ID) sfrdatao = cc_act_q[15:8];
  end

  assign compare = compare_q;
  assign ov      = ov_q;
  assign cocahl  = cocahl_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_ccu_compare_channel.sv
// Directed bench for ccu_compare_channel: vector table plus hand sequences for capture/reset.
module tb_ccu_compare_channel;
  import ccu_compare_channel_pkg::*;

  localparam logic [6:0] L = CCL1_ID;
  localparam logic [6:0] H = CCH1_ID;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] t2_count;
  logic        t2_ov;
  logic        capin;
  logic [1:0]  ccen_mode;
  logic [7:0]  sfrdatai;
  logic [6:0]  sfraddr;
  logic        sfrwe;
  logic [7:0]  sfrdatao;
  logic        compare;
  logic        ov;
  logic [1:0]  cocahl;
  logic        irq;

  int total = 0;
  int bad   = 0;

  ccu_compare_channel #(
    .CCL_ID (L),
    .CCH_ID (H)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .t2_count  (t2_count),
    .t2_ov     (t2_ov),
    .capin     (capin),
    .ccen_mode (ccen_mode),
    .sfrdatai  (sfrdatai),
    .sfraddr   (sfraddr),
    .sfrwe     (sfrwe),
    .sfrdatao  (sfrdatao),
    .compare   (compare),
    .ov        (ov),
    .cocahl    (cocahl),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] cnt;
    logic        tov;
    logic        we;
    logic [6:0]  addr;
    logic [7:0]  dat;
    logic        e_cmp;
    logic        e_irq;
    logic        e_ov;
    logic [1:0]  e_coc;
    logic [6:0]  raddr;
    logic [7:0]  e_rd;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  function automatic vec_t mk(logic [1:0] mode, logic [15:0] cnt, logic tov, logic we,
                              logic [6:0] addr, logic [7:0] dat, logic e_cmp, logic e_irq,
                              logic e_ov, logic [1:0] e_coc, logic [6:0] raddr,
                              logic [7:0] e_rd);
    vec_t v;
    v.mode = mode; v.cnt = cnt; v.tov = tov; v.we = we; v.addr = addr; v.dat = dat;
    v.e_cmp = e_cmp; v.e_irq = e_irq; v.e_ov = e_ov; v.e_coc = e_coc;
    v.raddr = raddr; v.e_rd = e_rd;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string nm, input logic e_cmp, input logic e_irq,
                            input logic e_ov, input logic [1:0] e_coc);
    check({nm, ".compare"}, {15'd0, compare}, {15'd0, e_cmp});
    check({nm, ".irq"}, {15'd0, irq}, {15'd0, e_irq});
    check({nm, ".ov"}, {15'd0, ov}, {15'd0, e_ov});
    check({nm, ".cocahl"}, {14'd0, cocahl}, {14'd0, e_coc});
  endtask

  task automatic check_rd(input string nm, input logic [6:0] a, input logic [7:0] exp);
    sfraddr = a;
    #1;
    check(nm, {8'd0, sfrdatao}, {8'd0, exp});
  endtask

  task automatic sfr_write(input logic [6:0] a, input logic [7:0] d);
    sfrwe = 1'b1; sfraddr = a; sfrdatai = d;
    step();
    sfrwe = 1'b0;
  endtask

  initial begin
    int ncmp;
    int nirq;

    //         mode cnt      tov we addr dat    cmp irq ov coc  raddr rd
    vecs[0]  = mk(2, 16'h0000, 0, 0, L, 8'h00, 0, 0, 0, 2, L, 8'h00);
    vecs[1]  = mk(0, 16'h0000, 0, 1, L, 8'h34, 0, 0, 0, 0, L, 8'h34);
    vecs[2]  = mk(0, 16'h0000, 0, 1, H, 8'h12, 0, 0, 0, 0, H, 8'h12);
    vecs[3]  = mk(2, 16'h1232, 0, 0, L, 8'h00, 0, 0, 0, 2, L, 8'h34);
    vecs[4]  = mk(2, 16'h1233, 0, 0, L, 8'h00, 0, 0, 0, 2, L, 8'h34);
    vecs[5]  = mk(2, 16'h1234, 0, 0, L, 8'h00, 1, 1, 0, 2, L, 8'h34);
    vecs[6]  = mk(2, 16'h1235, 0, 0, L, 8'h00, 0, 0, 0, 2, L, 8'h34);
    vecs[7]  = mk(2, 16'h1236, 1, 0, L, 8'h00, 0, 0, 1, 2, L, 8'h34);
    vecs[8]  = mk(2, 16'h1000, 0, 1, L, 8'h00, 0, 0, 0, 2, L, 8'h34);
    vecs[9]  = mk(2, 16'h1001, 0, 0, L, 8'h00, 0, 0, 0, 2, H, 8'h12);
    vecs[10] = mk(2, 16'h1234, 0, 0, L, 8'h00, 1, 1, 0, 2, L, 8'h34);
    vecs[11] = mk(2, 16'h1235, 1, 0, L, 8'h00, 0, 0, 1, 2, L, 8'h00);
    vecs[12] = mk(2, 16'h1200, 0, 0, L, 8'h00, 1, 1, 0, 2, H, 8'h12);
    vecs[13] = mk(2, 16'h0005, 1, 1, H, 8'hAB, 0, 0, 1, 2, H, 8'hAB);
    vecs[14] = mk(3, 16'h0F0F, 0, 1, L, 8'h55, 0, 1, 0, 3, L, 8'h0F);
    vecs[15] = mk(3, 16'h0F0F, 0, 1, H, 8'h77, 0, 0, 0, 3, H, 8'h77);
    vecs[16] = mk(3, 16'h0F0F, 0, 0, L, 8'h00, 0, 0, 0, 3, L, 8'h0F);
    vecs[17] = mk(0, 16'h0000, 0, 1, L, 8'h99, 0, 0, 0, 0, L, 8'h99);
    vecs[18] = mk(0, 16'h0000, 0, 0, L, 8'h00, 0, 0, 0, 0, 7'h10, 8'h00);
    vecs[19] = mk(0, 16'h7799, 0, 0, L, 8'h00, 0, 0, 0, 0, L, 8'h99);

    // Reset with busy inputs: everything must read back as zero.
    rst = 1'b1; t2_count = 16'h0000; t2_ov = 1'b1; capin = 1'b0; ccen_mode = 2'b10;
    sfrdatai = 8'h00; sfraddr = L; sfrwe = 1'b0;
    step(); step();
    check_outs("reset", 0, 0, 0, 2'b00);
    check_rd("reset.rd_l", L, 8'h00);
    check_rd("reset.rd_h", H, 8'h00);
    rst = 1'b0; t2_ov = 1'b0;

    for (int i = 0; i < NV; i++) begin
      ccen_mode = vecs[i].mode; t2_count = vecs[i].cnt; t2_ov = vecs[i].tov;
      sfrwe = vecs[i].we; sfraddr = vecs[i].addr; sfrdatai = vecs[i].dat;
      step();
      t2_ov = 1'b0; sfrwe = 1'b0;
      check_outs($sformatf("vec%0d", i), vecs[i].e_cmp, vecs[i].e_irq, vecs[i].e_ov,
                 vecs[i].e_coc);
      check_rd($sformatf("vec%0d.rd", i), vecs[i].raddr, vecs[i].e_rd);
    end

    // Timer stopped on the compare value: exactly one strobe.
    ccen_mode = 2'b00; t2_count = 16'h0000;
    sfr_write(L, 8'h34);
    sfr_write(H, 8'h12);
    ccen_mode = 2'b10; t2_count = 16'h1234;
    ncmp = 0; nirq = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      ncmp += int'(compare);
      nirq += int'(irq);
    end
    check("held.compare_pulses", 16'(ncmp), 16'd1);
    check("held.irq_pulses", 16'(nirq), 16'd1);

    // Entering capture mode with the pin already high must not capture.
    ccen_mode = 2'b00; capin = 1'b1;
    for (int i = 0; i < 4; i++) step();
    ccen_mode = 2'b01; t2_count = 16'hABCD; nirq = 0;
    for (int i = 0; i < 3; i++) begin step(); nirq += int'(irq); end
    capin = 1'b0;
    for (int i = 0; i < 3; i++) begin step(); nirq += int'(irq); end
    check("prehigh.irq_pulses", 16'(nirq), 16'd0);
    check_rd("prehigh.rd_l", L, 8'h34);

    // Pin capture: 3 clk latency; capture beats a same-cycle CCL write.
    capin = 1'b1;
    step();
    check("cap.irq_c1", {15'd0, irq}, 16'd0);
    step();
    check("cap.irq_c2", {15'd0, irq}, 16'd0);
    check_rd("cap.rd_l_before", L, 8'h34);
    sfr_write(L, 8'h11);
    check("cap.irq_c3", {15'd0, irq}, 16'd1);
    check_rd("cap.rd_l", L, 8'hCD);
    check_rd("cap.rd_h", H, 8'hAB);
    step();
    check("cap.irq_c4", {15'd0, irq}, 16'd0);

    // Reset one cycle after the pin rises: capture dropped, state cleared.
    capin = 1'b0; t2_count = 16'h5555;
    for (int i = 0; i < 3; i++) step();
    capin = 1'b1;
    step();
    rst = 1'b1; capin = 1'b0; t2_ov = 1'b1;
    step();
    check_outs("rstmid", 0, 0, 0, 2'b00);
    check_rd("rstmid.rd_l", L, 8'h00);
    check_rd("rstmid.rd_h", H, 8'h00);
    rst = 1'b0; t2_ov = 1'b0; nirq = 0;
    for (int i = 0; i < 4; i++) begin step(); nirq += int'(irq); end
    check("rstmid.irq_after", 16'(nirq), 16'd0);
    check_rd("rstmid.rd_l_after", L, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
